load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly upstream of the byte-addressed data memory.
- Takes one load/store request at a time from the execute stage over a valid/ready handshake.
- Drives the memory's 1-cycle-latency read port and write port 0.
- Returns sign- or zero-extended load data, or a store acknowledge, over a valid/ready response handshake.
- Implements byte and halfword stores as read-modify-write, because the memory only writes whole words.

Parameters:
- TAG_W, 5: width of the destination-register tag carried from request to response.
- MEM_BYTES, 256: size of the memory in bytes. An access with addr+3 >= MEM_BYTES (after alignment) is an error.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  high only in IDLE; request is accepted on an edge where valid&&ready.
- i_req_we  input  1  1=store, 0=load.
- i_req_size  input  2  00=byte, 01=half, 10=word, 11=illegal.
- i_req_unsigned  input  1  zero-extend the load result when 1, sign-extend when 0.
- i_req_addr  input  32  byte address.
- i_req_wdata  input  32  store data; the low 8/16/32 bits are used.
- i_req_tag  input  TAG_W  tag; echoed on the response.
- o_resp_valid  output  1  response present; held until accepted.
- i_resp_ready  input  1  consumer accepts the response.
- o_resp_data  output  32  load result; 0 for stores and errors.
- o_resp_tag  output  TAG_W  tag of the request being answered.
- o_resp_err  output  1  misaligned access, illegal size, or out-of-range address.
- o_r_mem_addr  output  32  memory read address, registered, always word-aligned.
- i_r_mem_data  input  32  memory read data, valid the cycle after the memory samples o_r_mem_addr.
- o_w_mem_addr  output  32  write address to memory port 0, word-aligned.
- o_w_mem_data  output  32  write data to port 0.
- o_w_mem_en  output  1  write enable to port 0; pulses for exactly one cycle per store. The top level ties port 1 enable to 0.

Behaviour:
- Byte order is big-endian: byte offset k (addr[1:0]) of a word occupies bits [31-8k -: 8]. Half at offset 0 is [31:16]; half at offset 2 is [15:0].
- Reset values (asynchronous, while i_rst_n is low):
  - state=IDLE.
  - o_req_ready=0 while reset is asserted.
  - o_resp_valid=0, o_resp_data=0, o_resp_tag=0, o_resp_err=0.
  - o_r_mem_addr=0, o_w_mem_addr=0, o_w_mem_data=0, o_w_mem_en=0.
- Reset mid-operation aborts immediately: o_w_mem_en drops, no write is issued, and the pending response is discarded.
- On accept, addr, size, unsigned, wdata, we and tag are latched. Alignment check:
  - Half requires addr[0]=0; word requires addr[1:0]=0.
  - Size 11, a misaligned address, or an out-of-range address goes to RESP with err=1. No memory access is made.
- States:
  - IDLE: waiting for a request.
  - RD_ISSUE: o_r_mem_addr={addr[31:2],2'b0}, held stable.
  - RD_WAIT: i_r_mem_data is valid this cycle.
  - WRITE: o_w_mem_en=1 for exactly this cycle.
  - RESP: o_resp_valid=1; on i_resp_ready the FSM goes to IDLE.
- Load path: IDLE -> RD_ISSUE -> RD_WAIT -> RESP.
  - On the RD_WAIT edge, the lane is extracted and extended into o_resp_data.
  - o_resp_valid rises 3 edges after the accept edge (the accept edge plus 2 more).
- Word store path: IDLE -> WRITE -> RESP. In WRITE, o_w_mem_addr=addr and o_w_mem_data=wdata.
- Byte/half store path: IDLE -> RD_ISSUE -> RD_WAIT -> WRITE -> RESP.
  - On the RD_WAIT edge, the selected lane of the read word is replaced with wdata[7:0] or wdata[15:0].
  - The merged word is registered into o_w_mem_data.
- Store response: o_resp_data=0, err=0.
- Backpressure: RESP holds data, tag and err stable until i_resp_ready. o_req_ready stays low, so there is exactly one outstanding request.
- Ordering: a store's write commits on the edge ending WRITE, which is before its response. A following load therefore always sees the stored value.
- o_w_mem_en is never high outside WRITE. o_r_mem_addr keeps its last value outside RD_ISSUE/RD_WAIT.

Test Plan:
- Store word 0xDEADBEEF at 0x10 -> o_w_mem_en high for exactly one cycle with addr 0x10, data 0xDEADBEEF; response err=0, data=0. A later word load at 0x10 returns 0xDEADBEEF.
- After the 0xDEADBEEF store:
  - byte signed load at 0x10 -> 0xFFFFFFDE
  - byte unsigned load at 0x13 -> 0x000000EF
  - half signed load at 0x12 -> 0xFFFFBEEF
  - half unsigned load at 0x10 -> 0x0000DEAD
  - in each case o_resp_valid rises 3 edges after accept.
- Store byte 0x55 at 0x11, then store half 0x1234 at 0x12 -> memory write data is 0xDE55BEEF, then 0xDE551234. A word load at 0x10 returns 0xDE551234.
- Error cases:
  - half load at 0x11 -> err=1, data=0, no read or write activity.
  - word store at 0xFE (MEM_BYTES=256) -> err=1.
  - size=11 -> err=1.
- Backpressure: hold i_resp_ready=0 for 5 cycles on a load with tag 7 -> data and tag remain stable, o_req_ready=0, and a new i_req_valid is not accepted until the handshake completes.
- Assert i_rst_n=0 during RD_WAIT of a byte store -> o_w_mem_en never pulses, the memory word is unchanged, outputs take reset values immediately, and the next request is accepted normally.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with big-endian lanes and RMW sub-word stores
module load_store_unit #(
  parameter int TAG_W     = 5,
  parameter int MEM_BYTES = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_we,
  input  logic [1:0]       i_req_size,
  input  logic             i_req_unsigned,
  input  logic [31:0]      i_req_addr,
  input  logic [31:0]      i_req_wdata,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic [31:0]      o_resp_data,
  output logic [TAG_W-1:0] o_resp_tag,
  output logic             o_resp_err,
  output logic [31:0]      o_r_mem_addr,
  input  logic [31:0]      i_r_mem_data,
  output logic [31:0]      o_w_mem_addr,
  output logic [31:0]      o_w_mem_data,
  output logic             o_w_mem_en
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP} state_t;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [1:0]  SZ_ILL    = 2'b11;
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state, state_nxt;
  logic        accept;
  logic        req_err;
  logic [31:0] aligned_addr;
  logic [32:0] addr_end;

  logic [1:0]  q_off;
  logic [1:0]  q_size;
  logic        q_unsigned;
  logic        q_we;
  logic [15:0] q_wdata;

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign o_req_ready  = (state == IDLE) && i_rst_n;
  assign o_resp_valid = (state == RESP);
  assign o_w_mem_en   = (state == WRITE);
  assign accept       = i_req_valid && o_req_ready;

  // Range check uses the word-aligned base so a word never straddles the top of memory.
  assign aligned_addr = {i_req_addr[31:2], 2'b00};
  assign addr_end     = {1'b0, aligned_addr} + 33'd3;
  assign req_err      = (i_req_size == SZ_ILL)
                     || ((i_req_size == SZ_HALF) && i_req_addr[0])
                     || ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00))
                     || (addr_end >= MEM_LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                               state_nxt = RESP;
          else if (i_req_we && i_req_size == SZ_WORD) state_nxt = WRITE;
          else                                       state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = q_we ? WRITE : RESP;
      WRITE:    state_nxt = RESP;
      RESP:     if (i_resp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Big-endian lane selection: byte offset 0 is the most significant byte.
  always_comb begin
    lane_byte = 8'h00;
    case (q_off)
      2'd0: lane_byte = i_r_mem_data[31:24];
      2'd1: lane_byte = i_r_mem_data[23:16];
      2'd2: lane_byte = i_r_mem_data[15:8];
      2'd3: lane_byte = i_r_mem_data[7:0];
      default: lane_byte = 8'h00;
    endcase
    lane_half = q_off[1] ? i_r_mem_data[15:0] : i_r_mem_data[31:16];

    load_data = i_r_mem_data;
    if (q_size == SZ_BYTE)
      load_data = q_unsigned ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
    else if (q_size == SZ_HALF)
      load_data = q_unsigned ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};

    merged = i_r_mem_data;
    if (q_size == SZ_BYTE) begin
      case (q_off)
        2'd0: merged[31:24] = q_wdata[7:0];
        2'd1: merged[23:16] = q_wdata[7:0];
        2'd2: merged[15:8]  = q_wdata[7:0];
        2'd3: merged[7:0]   = q_wdata[7:0];
        default: merged = i_r_mem_data;
      endcase
    end else if (q_off[1]) begin
      merged[15:0] = q_wdata;
    end else begin
      merged[31:16] = q_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_off        <= 2'b00;
      q_size       <= 2'b00;
      q_unsigned   <= 1'b0;
      q_we         <= 1'b0;
      q_wdata      <= 16'h0;
      o_resp_data  <= 32'h0;
      o_resp_tag   <= '0;
      o_resp_err   <= 1'b0;
      o_r_mem_addr <= 32'h0;
      o_w_mem_addr <= 32'h0;
      o_w_mem_data <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            q_off       <= i_req_addr[1:0];
            q_size      <= i_req_size;
            q_unsigned  <= i_req_unsigned;
            q_we        <= i_req_we;
            q_wdata     <= i_req_wdata[15:0];
            o_resp_tag  <= i_req_tag;
            o_resp_data <= 32'h0;
            o_resp_err  <= req_err;
            // Errored requests leave both memory address registers untouched.
            if (!req_err) begin
              if (i_req_we && i_req_size == SZ_WORD) begin
                o_w_mem_addr <= aligned_addr;
                o_w_mem_data <= i_req_wdata;
              end else begin
                o_r_mem_addr <= aligned_addr;
                if (i_req_we) o_w_mem_addr <= aligned_addr;
              end
            end
          end
        end
        RD_WAIT: begin
          if (q_we) o_w_mem_data <= merged;
          else      o_resp_data  <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit with a word memory model
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'b00;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_addr = 32'h0;
  logic [31:0] i_req_wdata = 32'h0;
  logic [4:0]  i_req_tag = 5'h0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b0;
  logic [31:0] o_resp_data;
  logic [4:0]  o_resp_tag;
  logic        o_resp_err;
  logic [31:0] o_r_mem_addr;
  logic [31:0] i_r_mem_data = 32'h0;
  logic [31:0] o_w_mem_addr;
  logic [31:0] o_w_mem_data;
  logic        o_w_mem_en;

  load_store_unit #(.TAG_W(5), .MEM_BYTES(256)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_tag(i_req_tag),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_data(o_resp_data), .o_resp_tag(o_resp_tag), .o_resp_err(o_resp_err),
    .o_r_mem_addr(o_r_mem_addr), .i_r_mem_data(i_r_mem_data),
    .o_w_mem_addr(o_w_mem_addr), .o_w_mem_data(o_w_mem_data), .o_w_mem_en(o_w_mem_en)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] mem [64] = '{default: 32'h0};
  always @(posedge i_clk) begin
    if (o_w_mem_en) mem[o_w_mem_addr[7:2]] <= o_w_mem_data;
    i_r_mem_data <= mem[o_r_mem_addr[7:2]];
  end

  int          wr_cnt = 0;
  logic [31:0] last_wa = 32'h0;
  logic [31:0] last_wd = 32'h0;
  always @(negedge i_clk) begin
    if (o_w_mem_en) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= o_w_mem_addr;
      last_wd <= o_w_mem_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  tag;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_edges;
    int          exp_wr;
    logic [31:0] exp_wd;
  } vec_t;

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] tag,
                        output logic [31:0] data, output logic err, output logic [4:0] rtag,
                        output int edges, output int wrs, output logic [31:0] raddr_before);
    int wr0;
    @(negedge i_clk);
    i_req_we = we; i_req_size = size; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wdata; i_req_tag = tag; i_req_valid = 1'b1;
    #1;
    check("req_ready_idle", {31'h0, o_req_ready}, 32'h1);
    wr0 = wr_cnt;
    raddr_before = o_r_mem_addr;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    #1;
    edges = 1;
    while (!o_resp_valid && edges < 20) begin
      @(negedge i_clk);
      #1;
      edges++;
    end
    if (!o_resp_valid) $display("FAIL resp_timeout: got no response expected one within 20 cycles");
    data = o_resp_data; err = o_resp_err; rtag = o_resp_tag;
    wrs = wr_cnt - wr0;
    i_resp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_resp_ready = 1'b0;
  endtask

  vec_t        v [15];
  logic [31:0] d, rb;
  logic        e;
  logic [4:0]  t;
  int          ed, w, wsnap;

  initial begin
    v[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd1,  32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
    v[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        5'd2,  32'hDEADBEEF, 1'b0, 3, 0, 32'h0};
    v[2]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        5'd3,  32'hFFFFFFDE, 1'b0, 3, 0, 32'h0};
    v[3]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        5'd4,  32'h000000EF, 1'b0, 3, 0, 32'h0};
    v[4]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        5'd5,  32'hFFFFBEEF, 1'b0, 3, 0, 32'h0};
    v[5]  = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        5'd6,  32'h0000DEAD, 1'b0, 3, 0, 32'h0};
    v[6]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF55, 5'd8,  32'h0,        1'b0, 4, 1, 32'hDE55BEEF};
    v[7]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD1234, 5'd9,  32'h0,        1'b0, 4, 1, 32'hDE551234};
    v[8]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        5'd10, 32'hDE551234, 1'b0, 3, 0, 32'h0};
    v[9]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        5'd11, 32'h00000055, 1'b0, 3, 0, 32'h0};
    v[10] = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        5'd12, 32'h0,        1'b1, 1, 0, 32'h0};
    v[11] = '{1'b1, 2'd2, 1'b0, 32'hFE, 32'h12345678, 5'd13, 32'h0,        1'b1, 1, 0, 32'h0};
    v[12] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        5'd14, 32'h0,        1'b1, 1, 0, 32'h0};
    v[13] = '{1'b0, 2'd0, 1'b1, 32'h100, 32'h0,       5'd15, 32'h0,        1'b1, 1, 0, 32'h0};
    v[14] = '{1'b0, 2'd2, 1'b0, 32'hFC, 32'h0,        5'd16, 32'h0,        1'b0, 3, 0, 32'h0};

    #1;
    check("rst_req_ready", {31'h0, o_req_ready}, 32'h0);
    check("rst_resp_valid", {31'h0, o_resp_valid}, 32'h0);
    check("rst_resp_data", o_resp_data, 32'h0);
    check("rst_r_mem_addr", o_r_mem_addr, 32'h0);
    check("rst_w_mem_en", {31'h0, o_w_mem_en}, 32'h0);
    check("rst_w_mem_data", o_w_mem_data, 32'h0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      do_req(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata, v[i].tag, d, e, t, ed, w, rb);
      check($sformatf("v%0d_data", i), d, v[i].exp_data);
      check($sformatf("v%0d_err", i), {31'h0, e}, {31'h0, v[i].exp_err});
      check($sformatf("v%0d_tag", i), {27'h0, t}, {27'h0, v[i].tag});
      check($sformatf("v%0d_edges", i), ed, v[i].exp_edges);
      check($sformatf("v%0d_writes", i), w, v[i].exp_wr);
      if (v[i].exp_wr != 0) begin
        check($sformatf("v%0d_wdata", i), last_wd, v[i].exp_wd);
        check($sformatf("v%0d_waddr", i), last_wa, {v[i].addr[31:2], 2'b00});
      end
      if (v[i].exp_err) check($sformatf("v%0d_raddr_kept", i), o_r_mem_addr, rb);
    end

    // Backpressure: response must hold while a second request waits.
    @(negedge i_clk);
    i_req_we = 1'b0; i_req_size = 2'd2; i_req_unsigned = 1'b0;
    i_req_addr = 32'h10; i_req_tag = 5'd7; i_req_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_we = 1'b1; i_req_addr = 32'h20; i_req_wdata = 32'h11111111; i_req_tag = 5'd20;
    wsnap = wr_cnt;
    for (int k = 0; k < 20 && !o_resp_valid; k++) @(negedge i_clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_valid", {31'h0, o_resp_valid}, 32'h1);
      check("bp_data", o_resp_data, 32'hDE551234);
      check("bp_tag", {27'h0, o_resp_tag}, 32'd7);
      check("bp_req_ready", {31'h0, o_req_ready}, 32'h0);
      @(negedge i_clk);
    end
    check("bp_no_write", wr_cnt - wsnap, 32'd0);
    i_resp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_resp_ready = 1'b0; i_req_valid = 1'b0;
    #1;
    check("bp_ready_after", {31'h0, o_req_ready}, 32'h1);
    check("bp_valid_after", {31'h0, o_resp_valid}, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd21, d, e, t, ed, w, rb);
    check("bp_second_not_taken", d, 32'h0);

    // Reset during RD_WAIT of a byte store.
    @(negedge i_clk);
    i_req_we = 1'b1; i_req_size = 2'd0; i_req_addr = 32'h10; i_req_wdata = 32'hAA;
    i_req_tag = 5'd3; i_req_valid = 1'b1;
    wsnap = wr_cnt;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("rr_resp_valid", {31'h0, o_resp_valid}, 32'h0);
    check("rr_w_mem_en", {31'h0, o_w_mem_en}, 32'h0);
    check("rr_r_mem_addr", o_r_mem_addr, 32'h0);
    check("rr_w_mem_addr", o_w_mem_addr, 32'h0);
    check("rr_req_ready", {31'h0, o_req_ready}, 32'h0);
    check("rr_resp_tag", {27'h0, o_resp_tag}, 32'h0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    check("rr_no_write", wr_cnt - wsnap, 32'd0);
    check("rr_mem_kept", mem[4], 32'hDE551234);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd22, d, e, t, ed, w, rb);
    check("rr_next_load", d, 32'hDE551234);
    check("rr_next_tag", {27'h0, t}, 32'd22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
